// File: rtl/edge_detector_pipe.sv
// edge_detector_pipe: per-channel box average, lagged difference, squared-magnitude threshold edge detect
module edge_detector_pipe #(
   parameter int NUM_PIXELS  = 5,
   parameter int PIXEL_WIDTH = 8,
   parameter int AVG_LOG2    = 1,
   parameter int LAG         = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic [NUM_PIXELS*PIXEL_WIDTH-1:0] in_pixels,
   input  logic [2*PIXEL_WIDTH-1:0]          threshold,
   output logic                              out_valid,
   output logic [NUM_PIXELS-1:0]             out_edge,
   output logic [NUM_PIXELS-1:0]             out_rising
);
   localparam int ND = 1 << AVG_LOG2;
   localparam int SW = PIXEL_WIDTH + AVG_LOG2;
   localparam int AP = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
   localparam int LP = LAG > 1 ? $clog2(LAG) : 1;
   localparam int WARMUP = ND + LAG;
   localparam int CW = $clog2(WARMUP + 1);
   logic [PIXEL_WIDTH-1:0]   sample_line [NUM_PIXELS][ND];
   logic [PIXEL_WIDTH-1:0]   avg_line [NUM_PIXELS][LAG];
   logic [SW-1:0]            sum [NUM_PIXELS];
   logic [PIXEL_WIDTH-1:0]   avg [NUM_PIXELS];
   logic [PIXEL_WIDTH-1:0]   mag [NUM_PIXELS];
   logic [2*PIXEL_WIDTH-1:0] sq [NUM_PIXELS];
   logic [NUM_PIXELS-1:0]    pos2, pos3;
   logic [AP-1:0]            sample_ptr;
   logic [LP-1:0]            avg_ptr;
   logic [CW-1:0]            count;
   logic                     v1, v2, v3, w1, w2, w3;
   // truncated box average taken straight from the running sums
   always_comb begin
      for (int i = 0; i < NUM_PIXELS; i++) avg[i] = PIXEL_WIDTH'(sum[i] >> AVG_LOG2);
   end
   // stage 1: running sum over the sample window plus warm-up counting, only on accepted samples
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_PIXELS; i++) begin
            sum[i] <= '0;
            for (int j = 0; j < ND; j++) sample_line[i][j] <= '0;
         end
         sample_ptr <= '0;
         count <= '0;
         v1 <= 1'b0;
         w1 <= 1'b0;
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
               sum[i] <= sum[i] + SW'(in_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH]) - SW'(sample_line[i][sample_ptr]);
               sample_line[i][sample_ptr] <= in_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
            sample_ptr <= sample_ptr == AP'(ND - 1) ? '0 : sample_ptr + 1'b1;
            count <= count == CW'(WARMUP) ? count : count + 1'b1;
            w1 <= count >= CW'(WARMUP - 1);
         end
      end
   end
   // stage 2: magnitude and sign of avg[n] - avg[n-LAG]; avg history advances per accepted sample
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_PIXELS; i++)
            for (int j = 0; j < LAG; j++) avg_line[i][j] <= '0;
         avg_ptr <= '0;
         v2 <= 1'b0;
         w2 <= 1'b0;
      end else begin
         v2 <= v1;
         w2 <= w1;
         if (v1) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
               mag[i] <= avg[i] >= avg_line[i][avg_ptr] ? avg[i] - avg_line[i][avg_ptr] : avg_line[i][avg_ptr] - avg[i];
               pos2[i] <= avg[i] > avg_line[i][avg_ptr];
               avg_line[i][avg_ptr] <= avg[i];
            end
            avg_ptr <= avg_ptr == LP'(LAG - 1) ? '0 : avg_ptr + 1'b1;
         end
      end
   end
   // stage 3: square the difference magnitude
   always_ff @(posedge clock) begin
      if (reset) begin
         v3 <= 1'b0;
         w3 <= 1'b0;
      end else begin
         v3 <= v2;
         w3 <= w2;
         pos3 <= pos2;
         for (int i = 0; i < NUM_PIXELS; i++) sq[i] <= (2*PIXEL_WIDTH)'(mag[i]) * (2*PIXEL_WIDTH)'(mag[i]);
      end
   end
   // output register: strict threshold compare, masked by valid and warm-up
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_edge <= '0;
         out_rising <= '0;
      end else begin
         out_valid <= v3;
         for (int i = 0; i < NUM_PIXELS; i++) begin
            out_edge[i] <= v3 && w3 && sq[i] > threshold;
            out_rising[i] <= v3 && w3 && sq[i] > threshold && pos3[i];
         end
      end
   end
endmodule
